win_tile_sched: RTL and testbench
=================================

# win_tile_sched

Tile scheduler for the F(2×2,3×3) Winograd convolution engine. It walks an H×W 8-bit feature map stored in a pixel memory and cuts it into overlapping 4×4 tiles at stride 2. Each tile is gathered into the engine's 128-bit tile bus, the engine's four combinational results are registered, and the resulting 2×2 output patch is written into an (H−2)×(W−2) result memory. It sits between the feature-map buffer, the combinational engine and the result buffer, and is started by the layer controller.

## Interface
Parameters:
- DATA_WIDTH, 19, width of engine results and of written words
- ADDR_W, 12, read and write address width
- MAX_DIM, 64, largest legal H or W; MAX_DIM² ≤ 2^ADDR_W
- DIM_W, $clog2(MAX_DIM+1), width of the dimension configuration ports

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a frame; sampled only in IDLE
- cfg_h  in  DIM_W  image height H; latched on accepted start
- cfg_w  in  DIM_W  image width W; latched on accepted start
- busy  out  1  high in FETCH, CAPT, EVAL, WRITE
- done  out  1  one-cycle pulse at frame end
- err  out  1  one-cycle pulse when start carries an illegal configuration
- rd_en  out  1  pixel memory read strobe
- rd_addr  out  ADDR_W  pixel address, row-major: row·W + col
- rd_data  in  8  signed pixel, valid exactly one cycle after rd_en
- tile  out  128  gathered tile; pixel k (k = r·4 + c) on tile[127−8k -: 8]
- win_r0..win_r3  in  DATA_WIDTH  engine results: r0 top-left, r1 top-right, r2 bottom-left, r3 bottom-right
- wr_en  out  1  result memory write strobe
- wr_addr  out  ADDR_W  result address: row·(W−2) + col
- wr_data  out  DATA_WIDTH  result word

## Operation
- Legal configuration: H and W even, 4 ≤ H,W ≤ MAX_DIM. Otherwise err pulses the cycle after start, the FSM stays in IDLE, and no memory access occurs.
- Tile grid: TY = (H−2)/2 rows, TX = (W−2)/2 columns, visited raster order (tx fastest).
- Tile (ty,tx) reads pixel k at ((2ty + r)·W + 2tx + c), k = 0..15 in order.
- FSM states:
  - IDLE: on start with a legal configuration, go to FETCH.
  - FETCH: 16 cycles. Cycle t issues read k=t; rd_data is captured into tile slot k−1 at t ≥ 1.
  - CAPT: 1 cycle. Captures slot 15.
  - EVAL: 1 cycle. tile is stable and win_r0..3 are registered into the result registers.
  - WRITE: 4 cycles, writing r0, r1, r2, r3 to (2ty+dy)·(W−2) + 2tx + dx, with (dy,dx) = (0,0), (0,1), (1,0), (1,1). Then go to FETCH for the next tile, or to DONE after the last tile.
  - DONE: 1 cycle with done=1, then IDLE.
- tile holds its last value outside FETCH and CAPT and is never cleared except by reset.
- Address arithmetic is unsigned at ADDR_W bits. No wrap is possible for legal configurations.
- wr_data is the registered engine result with no truncation or rounding.
- start while busy is ignored. cfg_h and cfg_w changes after acceptance are ignored.

## Timing
- Reset values: busy, done, err, rd_en, wr_en = 0; rd_addr, wr_addr, wr_data, tile = 0; state IDLE; counters 0.
- Reset at any point (including mid-FETCH or mid-WRITE) returns the block to IDLE next cycle. The partial tile is abandoned and no further reads or writes occur.
- Per-tile latency is 22 cycles (16 + 1 + 1 + 4). If start is accepted at cycle 0, the first rd_en is at cycle 1, the first wr_en at cycle 19, and done is high at cycle 1 + 22·TX·TY.
- rd_en and wr_en are never high in the same cycle.
- Engine path is combinational: win_r* are valid in the same cycle tile is stable, and are sampled at the end of EVAL.

## Structure
- Package win_pkg holds:
  - the state enum (IDLE, FETCH, CAPT, EVAL, WRITE, DONE)
  - the constants TILE_PIX=16, PIX_W=8, OUT_PER_TILE=4, TILE_BITS=128
- One sub-module, win_tile_addr_gen, holds the tx/ty/k/w counters and the rd_addr/wr_addr computation. It takes H, W and the step enables; it outputs the addresses and last-tile/last-pixel/last-write flags.
- The FSM, tile shift/capture register and result registers live in win_tile_sched.

## Test plan
- H=W=4, memory holds value k at address k → reads at 0..15 on cycles 1..16; tile = 0x000102…0F in EVAL; writes at addresses 0,1,2,3 on cycles 19..22; done at cycle 23.
- H=6, W=8 → 6 tiles. Tile (0,1) reads 2,3,4,5,10,11,…,29. Tile (1,2) writes 16,17,22,23. done at cycle 133. wr_data matches the golden F(2×2,3×3) model on a random image.
- start with H=5, W=8, or H=2 → err pulses once; busy stays 0; no rd_en or wr_en.
- rst asserted at the 8th FETCH cycle of tile 0 → IDLE next cycle, all outputs 0; a new start then completes with correct addresses.
- start pulsed repeatedly during a frame, and cfg changed mid-frame → no effect; the write sequence is identical to the clean run.
- Engine stub returning r0..r3 = −1, 2^18−1, −2^18, 0 → wr_data reproduces these values exactly, in order r0..r3.

Source files
------------

// File: rtl/win_pkg.sv
// Shared types and constants for the Winograd F(2x2,3x3) tile scheduler.
package win_pkg;

  localparam int TILE_PIX     = 16;
  localparam int PIX_W        = 8;
  localparam int OUT_PER_TILE = 4;
  localparam int TILE_BITS    = 128;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    CAPT,
    EVAL,
    WRITE,
    DONE
  } state_e;

  // A dimension is usable when it is even and a 4x4 tile fits inside it.
  function automatic logic dim_ok(input int unsigned d, input int unsigned max_dim);
    return ((d % 2) == 0) && (d >= 4) && (d <= max_dim);
  endfunction

endpackage

// File: rtl/win_tile_addr_gen.sv
// Tile/pixel/write counters and the pixel and result address arithmetic.
module win_tile_addr_gen
  import win_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DIM_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIM_W-1:0]  cfg_h,
  input  logic [DIM_W-1:0]  cfg_w,
  input  logic              clr,
  input  logic              k_step,
  input  logic              w_step,
  input  logic              tile_step,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last_pix,
  output logic              last_wr,
  output logic              last_tile
);

  logic [3:0]       k_q, k_d;
  logic [1:0]       w_q, w_d;
  logic [DIM_W-1:0] tx_q, tx_d, ty_q, ty_d;
  logic [DIM_W-1:0] tx_max, ty_max;
  logic [ADDR_W-1:0] w_ext, row2, col2, rd_row, wr_row;

  assign tx_max    = (cfg_w >> 1) - DIM_W'(2);
  assign ty_max    = (cfg_h >> 1) - DIM_W'(2);
  assign last_pix  = (k_q == 4'd15);
  assign last_wr   = (w_q == 2'd3);
  assign last_tile = (tx_q == tx_max) && (ty_q == ty_max);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    k_d  = k_q;
    w_d  = w_q;
    tx_d = tx_q;
    ty_d = ty_q;
    if (clr) begin
      k_d  = '0;
      w_d  = '0;
      tx_d = '0;
      ty_d = '0;
    end else begin
      if (k_step) k_d = k_q + 4'd1;
      if (w_step) w_d = w_q + 2'd1;
      if (tile_step) begin
        if (last_tile) begin
          tx_d = '0;
          ty_d = '0;
        end else if (tx_q == tx_max) begin
          tx_d = '0;
          ty_d = ty_q + DIM_W'(1);
        end else begin
          tx_d = tx_q + DIM_W'(1);
        end
      end
    end
  end

  // Tile origin is (2ty, 2tx); k selects the 4x4 offset, w the 2x2 offset.
  always_comb begin
    w_ext   = ADDR_W'(cfg_w);
    row2    = ADDR_W'({ty_q, 1'b0});
    col2    = ADDR_W'({tx_q, 1'b0});
    rd_row  = row2 + ADDR_W'(k_q[3:2]);
    wr_row  = row2 + ADDR_W'(w_q[1]);
    rd_addr = rd_row * w_ext + col2 + ADDR_W'(k_q[1:0]);
    wr_addr = wr_row * (w_ext - ADDR_W'(2)) + col2 + ADDR_W'(w_q[0]);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q  <= '0;
      w_q  <= '0;
      tx_q <= '0;
      ty_q <= '0;
    end else begin
      k_q  <= k_d;
      w_q  <= w_d;
      tx_q <= tx_d;
      ty_q <= ty_d;
    end
  end

endmodule

// File: rtl/win_tile_sched.sv
// Frame FSM, tile gather register and result registers for the Winograd engine.
module win_tile_sched
  import win_pkg::*;
#(
  parameter int DATA_WIDTH = 19,
  parameter int ADDR_W     = 12,
  parameter int MAX_DIM    = 64,
  parameter int DIM_W      = $clog2(MAX_DIM + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIM_W-1:0]      cfg_h,
  input  logic [DIM_W-1:0]      cfg_w,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [PIX_W-1:0]      rd_data,
  output logic [TILE_BITS-1:0]  tile,
  input  logic [DATA_WIDTH-1:0] win_r0,
  input  logic [DATA_WIDTH-1:0] win_r1,
  input  logic [DATA_WIDTH-1:0] win_r2,
  input  logic [DATA_WIDTH-1:0] win_r3,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data
);

  state_e state_q, state_d;
  logic   busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic   rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic   rd_vld_q, rd_vld_d;
  logic [3:0]                 cap_idx_q, cap_idx_d;
  logic [6:0]                 cap_lsb;
  logic [DIM_W-1:0]           h_q, h_d, w_q, w_d;
  logic [TILE_BITS-1:0]       tile_q, tile_d;
  logic [OUT_PER_TILE-1:0][DATA_WIDTH-1:0] res_q, res_d;
  logic clr, k_step, w_step, tile_step;
  logic last_pix, last_wr, last_tile;

  win_tile_addr_gen #(
    .ADDR_W (ADDR_W),
    .DIM_W  (DIM_W)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .cfg_h     (h_q),
    .cfg_w     (w_q),
    .clr       (clr),
    .k_step    (k_step),
    .w_step    (w_step),
    .tile_step (tile_step),
    .rd_addr   (rd_addr),
    .wr_addr   (wr_addr),
    .last_pix  (last_pix),
    .last_wr   (last_wr),
    .last_tile (last_tile)
  );

  // Slot k lives at bits (15-k)*8 +: 8, i.e. ~k shifted left by 3.
  assign cap_lsb = {~cap_idx_q, 3'b000};

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    h_d       = h_q;
    w_d       = w_q;
    tile_d    = tile_q;
    res_d     = res_q;
    clr       = 1'b0;
    k_step    = 1'b0;
    w_step    = 1'b0;
    tile_step = 1'b0;
    rd_vld_d  = rd_en_q;
    cap_idx_d = cap_idx_q;

    // Data returns one cycle after each strobe, so capture trails the reads by one slot.
    if (rd_vld_q) begin
      tile_d[cap_lsb +: PIX_W] = rd_data;
      cap_idx_d                = cap_idx_q + 4'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (dim_ok(32'(cfg_h), MAX_DIM) && dim_ok(32'(cfg_w), MAX_DIM)) begin
            state_d = FETCH;
            busy_d  = 1'b1;
            rd_en_d = 1'b1;
            clr     = 1'b1;
            h_d     = cfg_h;
            w_d     = cfg_w;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FETCH: begin
        k_step = 1'b1;
        if (last_pix) state_d = CAPT;
        else          rd_en_d = 1'b1;
      end
      CAPT: state_d = EVAL;
      EVAL: begin
        res_d   = {win_r3, win_r2, win_r1, win_r0};
        state_d = WRITE;
        wr_en_d = 1'b1;
      end
      WRITE: begin
        w_step = 1'b1;
        res_d  = {DATA_WIDTH'(0), res_q[OUT_PER_TILE-1:1]};
        if (last_wr) begin
          tile_step = 1'b1;
          if (last_tile) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = FETCH;
            rd_en_d = 1'b1;
          end
        end else begin
          wr_en_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: tile and result registers are reset too, because tile and wr_data must read 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_vld_q  <= 1'b0;
      cap_idx_q <= '0;
      h_q       <= '0;
      w_q       <= '0;
      tile_q    <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      rd_vld_q  <= rd_vld_d;
      cap_idx_q <= cap_idx_d;
      h_q       <= h_d;
      w_q       <= w_d;
      tile_q    <= tile_d;
      res_q     <= res_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rd_en   = rd_en_q;
  assign wr_en   = wr_en_q;
  assign tile    = tile_q;
  assign wr_data = res_q[0];

endmodule

// File: tb/tb_win_tile_sched.sv
// Directed bench for win_tile_sched with a behavioural pixel memory and engine.
module tb_win_tile_sched;

  localparam int DW  = 19;
  localparam int AW  = 12;
  localparam int DMW = 7;
  localparam int G [9] = '{1, -2, 3, 0, 2, -1, -3, 1, 2};

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [DMW-1:0] cfg_h = '0, cfg_w = '0;
  logic           busy, done, err, rd_en, wr_en;
  logic [AW-1:0]  rd_addr, wr_addr;
  logic [7:0]     rd_data = '0;
  logic [127:0]   tile;
  logic [DW-1:0]  win_r0, win_r1, win_r2, win_r3, wr_data;

  logic [7:0] pix [0:4095];
  bit         stub_mode = 1'b0;

  int n_cmp = 0, n_err = 0;
  int cyc_cnt = 0, c0 = 0;
  int rd_a[$], rd_c[$], wr_a[$], wr_c[$];
  logic [DW-1:0] wr_d[$];
  int clean_a[$];
  logic [DW-1:0] clean_d[$];
  int done_n = 0, done_c = 0, err_n = 0, err_c = 0, both_n = 0;
  bit busy_seen = 1'b0;

  win_tile_sched #(.DATA_WIDTH(DW), .ADDR_W(AW), .MAX_DIM(64), .DIM_W(DMW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_h(cfg_h), .cfg_w(cfg_w),
    .busy(busy), .done(done), .err(err),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .tile(tile),
    .win_r0(win_r0), .win_r1(win_r1), .win_r2(win_r2), .win_r3(win_r3),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(posedge clk) if (rd_en) rd_data <= pix[rd_addr];

  // 3x3 correlation over the 4x4 tile at output offset (dy,dx).
  function automatic int corr(input logic [127:0] t, input int dy, input int dx);
    int s = 0;
    logic [7:0] p;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        p = t[(15 - ((i + dy) * 4 + j + dx)) * 8 +: 8];
        s += int'($signed(p)) * G[i * 3 + j];
      end
    return s;
  endfunction

  always_comb begin
    if (stub_mode) begin
      win_r0 = 19'h7FFFF;
      win_r1 = 19'h3FFFF;
      win_r2 = 19'h40000;
      win_r3 = 19'h00000;
    end else begin
      win_r0 = DW'(corr(tile, 0, 0));
      win_r1 = DW'(corr(tile, 0, 1));
      win_r2 = DW'(corr(tile, 1, 0));
      win_r3 = DW'(corr(tile, 1, 1));
    end
  end

  // Golden output pixel straight from the image, independent of tiling.
  function automatic logic [DW-1:0] model(input int addr, input int w);
    int y, x, s;
    y = addr / (w - 2);
    x = addr % (w - 2);
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += int'($signed(pix[(y + i) * w + x + j])) * G[i * 3 + j];
    return DW'(s);
  endfunction

  always @(negedge clk) begin
    if (rd_en) begin rd_a.push_back(int'(rd_addr)); rd_c.push_back(cyc_cnt); end
    if (wr_en) begin wr_a.push_back(int'(wr_addr)); wr_d.push_back(wr_data); wr_c.push_back(cyc_cnt); end
    if (done) begin done_n++; done_c = cyc_cnt; end
    if (err) begin err_n++; err_c = cyc_cnt; end
    if (busy) busy_seen = 1'b1;
    if (rd_en && wr_en) both_n++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_a.delete(); rd_c.delete();
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    done_n = 0; err_n = 0; busy_seen = 1'b0;
  endtask

  task automatic start_frame(input int h, input int w);
    cfg_h = DMW'(h);
    cfg_w = DMW'(w);
    start = 1'b1;
    c0    = cyc_cnt;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_n == 0 && n < budget) begin tick(); n++; end
    check("done_seen", 128'(done_n != 0), 128'(1));
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_busy"},    128'(busy),    '0);
    check({pfx, "_done"},    128'(done),    '0);
    check({pfx, "_err"},     128'(err),     '0);
    check({pfx, "_rd_en"},   128'(rd_en),   '0);
    check({pfx, "_wr_en"},   128'(wr_en),   '0);
    check({pfx, "_rd_addr"}, 128'(rd_addr), '0);
    check({pfx, "_wr_addr"}, 128'(wr_addr), '0);
    check({pfx, "_wr_data"}, 128'(wr_data), '0);
    check({pfx, "_tile"},    tile,          '0);
  endtask

  task automatic cmp_clean(input string pfx);
    check({pfx, "_nwr"}, 128'(wr_a.size()), 128'(clean_a.size()));
    for (int i = 0; i < wr_a.size() && i < clean_a.size(); i++) begin
      check($sformatf("%s_wa%0d", pfx, i), 128'(wr_a[i]), 128'(clean_a[i]));
      check($sformatf("%s_wd%0d", pfx, i), 128'(wr_d[i]), 128'(clean_d[i]));
    end
  endtask

  initial begin
    int t01 [16] = '{2, 3, 4, 5, 10, 11, 12, 13, 18, 19, 20, 21, 26, 27, 28, 29};
    int t12 [4]  = '{16, 17, 22, 23};
    int bad_h [3] = '{5, 2, 4};
    int bad_w [3] = '{8, 8, 66};
    int hits [24];
    int once;

    for (int a = 0; a < 4096; a++) pix[a] = 8'(a);

    // Reset state
    repeat (3) tick();
    check_zero("rst");
    rst = 1'b0;
    tick();

    // 4x4 frame with pixel value == address
    clear_logs();
    start_frame(4, 4);
    check("t1_busy", 128'(busy), 128'(1));
    wait_done(60);
    check("t1_nrd", 128'(rd_a.size()), 128'(16));
    for (int i = 0; i < rd_a.size() && i < 16; i++) begin
      check($sformatf("t1_ra%0d", i), 128'(rd_a[i]), 128'(i));
      check($sformatf("t1_rc%0d", i), 128'(rd_c[i] - c0), 128'(i + 1));
    end
    check("t1_tile", tile, 128'h000102030405060708090a0b0c0d0e0f);
    check("t1_nwr", 128'(wr_a.size()), 128'(4));
    for (int i = 0; i < wr_a.size() && i < 4; i++) begin
      check($sformatf("t1_wa%0d", i), 128'(wr_a[i]), 128'(i));
      check($sformatf("t1_wc%0d", i), 128'(wr_c[i] - c0), 128'(19 + i));
      check($sformatf("t1_wd%0d", i), 128'(wr_d[i]), 128'(model(i, 4)));
    end
    check("t1_done_cyc", 128'(done_c - c0), 128'(23));
    tick();

    // 6x8 frame on a random image
    for (int a = 0; a < 48; a++) pix[a] = 8'($urandom);
    clear_logs();
    start_frame(6, 8);
    wait_done(200);
    check("t2_done_cyc", 128'(done_c - c0), 128'(133));
    check("t2_nrd", 128'(rd_a.size()), 128'(96));
    for (int i = 0; i < 16 && rd_a.size() == 96; i++)
      check($sformatf("t2_t01_ra%0d", i), 128'(rd_a[16 + i]), 128'(t01[i]));
    check("t2_nwr", 128'(wr_a.size()), 128'(24));
    for (int i = 0; i < 4 && wr_a.size() == 24; i++)
      check($sformatf("t2_t12_wa%0d", i), 128'(wr_a[20 + i]), 128'(t12[i]));
    foreach (hits[i]) hits[i] = 0;
    for (int i = 0; i < wr_a.size(); i++) begin
      if (wr_a[i] < 24) hits[wr_a[i]]++;
      check($sformatf("t2_wd%0d", i), 128'(wr_d[i]), 128'(model(wr_a[i], 8)));
    end
    once = 0;
    foreach (hits[i]) if (hits[i] == 1) once++;
    check("t2_cover", 128'(once), 128'(24));
    clean_a = wr_a;
    clean_d = wr_d;
    tick();

    // Illegal configurations
    for (int b = 0; b < 3; b++) begin
      clear_logs();
      start_frame(bad_h[b], bad_w[b]);
      repeat (4) tick();
      check($sformatf("t3_err_n%0d", b),   128'(err_n),       128'(1));
      check($sformatf("t3_err_cyc%0d", b), 128'(err_c - c0),  128'(1));
      check($sformatf("t3_busy%0d", b),    128'(busy_seen),   '0);
      check($sformatf("t3_nrd%0d", b),     128'(rd_a.size()), '0);
      check($sformatf("t3_nwr%0d", b),     128'(wr_a.size()), '0);
    end

    // Reset in the 8th fetch cycle of tile 0, then a clean rerun
    clear_logs();
    start_frame(6, 8);
    while (cyc_cnt < c0 + 8) tick();
    rst = 1'b1;
    tick();
    check_zero("t4");
    rst = 1'b0;
    repeat (5) tick();
    check("t4_nrd", 128'(rd_a.size()), 128'(8));
    check("t4_nwr", 128'(wr_a.size()), '0);
    clear_logs();
    start_frame(6, 8);
    wait_done(200);
    check("t4_done_cyc", 128'(done_c - c0), 128'(133));
    cmp_clean("t4");
    tick();

    // start and cfg noise during a frame
    clear_logs();
    start_frame(6, 8);
    for (int i = 0; cyc_cnt < c0 + 130; i++) begin
      start = (i % 5 == 2);
      cfg_h = (i % 3 == 0) ? 7'd4 : 7'd10;
      cfg_w = (i % 2 == 0) ? 7'd12 : 7'd5;
      tick();
    end
    start = 1'b0;
    wait_done(20);
    check("t5_done_cyc", 128'(done_c - c0), 128'(133));
    cmp_clean("t5");
    repeat (3) tick();
    check("t5_idle", 128'(busy), '0);

    // Extreme engine results pass through untouched
    stub_mode = 1'b1;
    clear_logs();
    start_frame(4, 4);
    wait_done(60);
    check("t6_nwr", 128'(wr_a.size()), 128'(4));
    if (wr_a.size() == 4) begin
      check("t6_r0", 128'(wr_d[0]), 128'(19'h7FFFF));
      check("t6_r1", 128'(wr_d[1]), 128'(19'h3FFFF));
      check("t6_r2", 128'(wr_d[2]), 128'(19'h40000));
      check("t6_r3", 128'(wr_d[3]), 128'(19'h00000));
    end

    check("rd_wr_overlap", 128'(both_n), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
